// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding and default parameters for the LED mode controller.
// Latency: none (declarations only).
// Backpressure: none.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_SCROLL = 2'b11
    } led_mode_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_TICK_DIV = 50_000_000;
    localparam int DEF_PWM_W    = 4;

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Bundle of mode/pattern/brightness inputs and LED drive/tick outputs.
// Latency: none (wiring only).
// Backpressure: none; all signals are sampled every cycle.
interface led_mode_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PWM_W = DEF_PWM_W
);

    led_mode_t          mode;
    logic [WIDTH-1:0]   data;
    logic [PWM_W-1:0]   duty;
    logic [WIDTH-1:0]   out;
    logic               tick;

    modport master (output mode, data, duty, input out, tick);
    modport slave  (input mode, data, duty, output out, tick);

endinterface

// File: rtl/led_mode_ctrl_tick_gen.sv
// Animation prescaler: counts 0..TICK_DIV-1 and flags the last count.
// Latency: tick is combinational from the count; clear lands next cycle.
// Backpressure: none; free-running unless cleared.
module tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count up, wrapping at the last value; clear restarts a full period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_mode_ctrl.sv
// LED driver with OFF/DIRECT/BLINK/SCROLL patterns and PWM brightness.
// Latency: out is registered, 1 cycle from mode/data/duty to LEDs.
// Backpressure: none; inputs are consumed every cycle.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PWM_W    = DEF_PWM_W
) (
    input  logic            clk,
    input  logic            reset_n,
    led_mode_ctrl_if.slave  bus
);

    led_mode_t          mode_q;
    logic               mode_chg;
    logic               tick;
    logic               phase;
    logic [WIDTH-1:0]   scroll_q;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               pwm_en;
    logic [WIDTH-1:0]   pat;

    // After reset mode_q is OFF, so the first non-OFF cycle counts as a change.
    assign mode_chg = (bus.mode != mode_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (mode_chg),
        .tick    (tick)
    );

    assign bus.tick = tick;

    // Track the previous mode for change detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= bus.mode;
        end
    end

    // Blink phase and scroll register: a mode change reloads both and
    // overrides any tick landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase    <= 1'b1;
            scroll_q <= '0;
        end else if (mode_chg) begin
            phase    <= 1'b1;
            scroll_q <= bus.data;
        end else if (tick) begin
            if (bus.mode == MODE_BLINK) begin
                phase <= ~phase;
            end
            if (bus.mode == MODE_SCROLL) begin
                scroll_q <= {scroll_q[WIDTH-2:0], scroll_q[WIDTH-1]};
            end
        end
    end

    // Free-running PWM phase; never disturbed by duty or mode changes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Select the pre-PWM pattern for the current mode.
    always_comb begin
        pat = '0;
        case (bus.mode)
            MODE_OFF:    pat = '0;
            MODE_DIRECT: pat = bus.data;
            MODE_BLINK:  pat = phase ? bus.data : '0;
            MODE_SCROLL: pat = scroll_q;
            default:     pat = '0;
        endcase
    end

    // Full-scale duty is always on; zero duty never matches the compare.
    always_comb begin
        pwm_en = (bus.duty == '1) || (pwm_cnt < bus.duty);
    end

    // Registered LED drive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.out <= '0;
        end else begin
            bus.out <= pat & {WIDTH{pwm_en}};
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;
    import led_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    led_mode_ctrl_if #(.WIDTH(W), .PWM_W(PW)) bus ();

    led_mode_ctrl #(
        .WIDTH    (W),
        .TICK_DIV (TD),
        .PWM_W    (PW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles since last prescaler restart, cycles since
    // reset, ticks seen since the last mode change, value captured then.
    bit        mvalid = 1'b0;
    int        m_pre, m_pwm, m_nticks;
    led_mode_t m_mode_q;
    logic [7:0] m_load, m_out;
    logic       obs_tick;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [15:0] t;
        t = {v, v} << k;
        return t[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: apply inputs, check tick mid-cycle, advance model,
    // then check registered out just after the edge.
    task automatic cyc(input logic rst_n, input led_mode_t m,
                       input logic [7:0] d, input logic [3:0] du);
        bit         chg, tick_now, phase_on, pwm_on;
        logic [7:0] scr, pat;
        reset_n   = rst_n;
        bus.mode  = m;
        bus.data  = d;
        bus.duty  = du;
        #1;
        obs_tick = bus.tick;
        if (mvalid) chk("tick", 32'(bus.tick), 32'(m_pre == TD - 1));
        if (!rst_n) begin
            m_pre = 0; m_pwm = 0; m_nticks = 0;
            m_mode_q = MODE_OFF; m_load = '0; m_out = '0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            tick_now = (m_pre == TD - 1);
            chg      = (m != m_mode_q);
            phase_on = (m_mode_q != MODE_BLINK) || (m_nticks % 2 == 0);
            scr      = (m_mode_q == MODE_SCROLL) ? rotl(m_load, m_nticks % W) : m_load;
            case (m)
                MODE_DIRECT: pat = d;
                MODE_BLINK:  pat = phase_on ? d : 8'h00;
                MODE_SCROLL: pat = scr;
                default:     pat = 8'h00;
            endcase
            pwm_on = (du == 4'hF) || (m_pwm < int'(du));
            m_out  = pwm_on ? pat : 8'h00;
            m_pwm  = (m_pwm + 1) % 16;
            if (chg) begin
                m_pre = 0; m_load = d; m_nticks = 0;
            end else begin
                m_pre = (m_pre + 1) % TD;
                if (tick_now) m_nticks++;
            end
            m_mode_q = m;
        end
        @(posedge clk);
        #1;
        if (mvalid) chk("out", 32'(bus.out), 32'(m_out));
    endtask

    initial begin
        int cnt;
        int hold;
        led_mode_t rm;
        logic [3:0] rdu;

        // Reset
        cyc(1'b0, MODE_OFF, 8'h00, 4'hF);
        cyc(1'b0, MODE_OFF, 8'h00, 4'hF);
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        cyc(1'b1, MODE_OFF, 8'h00, 4'hF);

        // DIRECT A5 at full brightness, tick every 4 cycles
        cyc(1'b1, MODE_DIRECT, 8'hA5, 4'hF);
        chk("direct_a5", 32'(bus.out), 32'hA5);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, MODE_DIRECT, 8'hA5, 4'hF);
            if (obs_tick) cnt++;
        end
        chk("tick_period", 32'(cnt), 32'd2);

        // BLINK FF: starts lit, alternates every 4 cycles
        cyc(1'b1, MODE_BLINK, 8'hFF, 4'hF);
        chk("blink_first", 32'(bus.out), 32'hFF);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, MODE_BLINK, 8'hFF, 4'hF);
            if (i == 4) chk("blink_on_end", 32'(bus.out), 32'hFF);
            if (i == 5) chk("blink_off", 32'(bus.out), 32'h00);
            if (i == 9) chk("blink_on_again", 32'(bus.out), 32'hFF);
        end

        // SCROLL 81: rotates to 03, 06, 0C; data change mid-scroll ignored
        cyc(1'b1, MODE_SCROLL, 8'h81, 4'hF);
        for (int i = 1; i <= 14; i++) begin
            cyc(1'b1, MODE_SCROLL, (i < 7) ? 8'h81 : 8'h00, 4'hF);
            if (i == 6)  chk("scroll_03", 32'(bus.out), 32'h03);
            if (i == 10) chk("scroll_06", 32'(bus.out), 32'h06);
            if (i == 14) chk("scroll_0c", 32'(bus.out), 32'h0C);
        end

        // PWM: duty 4 lights 4 of 16 cycles; duty 0 stays dark
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, MODE_DIRECT, 8'hFF, 4'h4);
            if (bus.out === 8'hFF) cnt++;
        end
        chk("pwm_duty4", 32'(cnt), 32'd8);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, MODE_DIRECT, 8'hFF, 4'h0);
            if (bus.out !== 8'h00) cnt++;
        end
        chk("pwm_duty0", 32'(cnt), 32'd0);

        // BLINK -> SCROLL on the tick cycle: load without rotation
        for (int k = 0; k < 16 && (k < 2 || m_pre != TD - 1); k++)
            cyc(1'b1, MODE_BLINK, 8'h3C, 4'hF);
        cyc(1'b1, MODE_SCROLL, 8'h5A, 4'hF);
        chk("collide_tick", 32'(obs_tick), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, MODE_SCROLL, 8'h5A, 4'hF);
            if (i == 1) chk("collide_load", 32'(bus.out), 32'h5A);
            if (i == 3) chk("collide_notick", 32'(obs_tick), 32'h0);
            if (i == 4) chk("collide_tick4", 32'(obs_tick), 32'h1);
            if (i == 5) chk("collide_rot", 32'(bus.out), 32'hB4);
        end

        // One-cycle reset mid-SCROLL, then reload from data
        cyc(1'b0, MODE_SCROLL, 8'h77, 4'hF);
        chk("midrst_out", 32'(bus.out), 32'h00);
        cyc(1'b1, MODE_SCROLL, 8'h77, 4'hF);
        chk("midrst_tick", 32'(obs_tick), 32'h0);
        cyc(1'b1, MODE_SCROLL, 8'h77, 4'hF);
        chk("midrst_reload", 32'(bus.out), 32'h77);

        // Randomized traffic against the model
        hold = 0;
        rm = MODE_OFF;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                rm   = led_mode_t'($urandom_range(0, 3));
                hold = $urandom_range(1, 24);
            end
            hold--;
            case ($urandom_range(0, 3))
                0:       rdu = 4'h0;
                1:       rdu = 4'hF;
                default: rdu = 4'($urandom_range(0, 15));
            endcase
            cyc(($urandom_range(0, 63) != 0), rm, 8'($urandom), rdu);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
